// File: rtl/axis_mirrors_pkt.sv
// axis_mirrors_pkt: packet-aware AXI-stream broadcaster.
// One input stream is copied into NUM independent per-channel FIFOs.
// In CDS_MODE the destination mask is taken from dest_mask on the first beat
// of a packet and held for the rest of it; FULL_MODE sends every beat to all
// channels. A packet whose effective mask is empty is swallowed and flagged
// on pkt_drop the cycle after its last beat is accepted.
module axis_mirrors_pkt #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned NUM   = 4,
  parameter int unsigned DEPTH = 4,
  parameter string       MODE  = "CDS_MODE"
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NUM-1:0]         dest_mask,
  input  logic [DSIZE-1:0]       s_tdata,
  input  logic                   s_tlast,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [NUM*DSIZE-1:0]   m_tdata,
  output logic [NUM-1:0]         m_tlast,
  output logic [NUM-1:0]         m_tvalid,
  input  logic [NUM-1:0]         m_tready,
  output logic                   pkt_drop
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam bit            FULL     = (MODE == "FULL_MODE");
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_SOP,
    ST_BODY
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NUM-1:0]   r_mask;
  logic             r_pkt_drop;

  logic [DSIZE:0]   r_mem  [NUM][DEPTH];
  logic [AW-1:0]    r_wptr [NUM];
  logic [AW-1:0]    r_rptr [NUM];
  logic [AW:0]      r_cnt  [NUM];

  logic [NUM-1:0]   w_eff;
  logic [NUM-1:0]   w_full;
  logic [NUM-1:0]   w_push;
  logic [NUM-1:0]   w_pop;
  logic             w_room;
  logic             w_accept;

  // Effective destination mask: fresh on a first beat, latched otherwise
  always_comb begin
    w_eff = r_mask;
    if (r_state == ST_SOP) begin
      w_eff = FULL ? '1 : dest_mask;
    end
  end

  // Per-channel status and head-of-queue outputs, all from registered state
  always_comb begin
    w_full   = '0;
    m_tvalid = '0;
    m_tlast  = '0;
    m_tdata  = '0;
    for (int unsigned c = 0; c < NUM; c++) begin
      w_full[c]                  = (r_cnt[c] == CNT_FULL);
      m_tvalid[c]                = (r_cnt[c] != '0);
      m_tlast[c]                 = r_mem[c][r_rptr[c]][DSIZE];
      m_tdata[c*DSIZE +: DSIZE]  = r_mem[c][r_rptr[c]][DSIZE-1:0];
    end
  end

  // Input ready: every selected channel must have a free slot; pops this
  // cycle are deliberately ignored so m_tready never reaches s_tready
  always_comb begin
    w_room = 1'b1;
    for (int unsigned c = 0; c < NUM; c++) begin
      if (w_eff[c] && w_full[c]) begin
        w_room = 1'b0;
      end
    end
  end

  assign s_tready = !rst && w_room;
  assign w_accept = s_tvalid && s_tready;
  assign pkt_drop = r_pkt_drop;

  // Push/pop strobes per channel
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int unsigned c = 0; c < NUM; c++) begin
      w_push[c] = w_accept && w_eff[c];
      w_pop[c]  = (r_cnt[c] != '0) && m_tready[c];
    end
  end

  // Packet framing next state: any accepted tlast returns to first-beat
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = s_tlast ? ST_SOP : ST_BODY;
    end
  end

  // Packet framing state, latched mask and drop pulse
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= ST_SOP;
      r_mask     <= '0;
      r_pkt_drop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pkt_drop <= w_accept && s_tlast && (w_eff == '0);
      if (w_accept && (r_state == ST_SOP)) begin
        r_mask <= w_eff;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM; c++) begin
        if (w_push[c]) begin
          r_wptr[c] <= r_wptr[c] + 1'b1;
        end
        if (w_pop[c]) begin
          r_rptr[c] <= r_rptr[c] + 1'b1;
        end
        case ({w_push[c], w_pop[c]})
          2'b10:   r_cnt[c] <= r_cnt[c] + 1'b1;
          2'b01:   r_cnt[c] <= r_cnt[c] - 1'b1;
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
    end
  end

  // FIFO storage: {tlast, tdata} written at the tail of each selected channel
  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < NUM; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wptr[c]] <= {s_tlast, s_tdata};
      end
    end
  end

endmodule

// File: tb/tb_axis_mirrors_pkt.sv
// Directed self-checking bench for axis_mirrors_pkt (CDS and FULL instances).
module tb_axis_mirrors_pkt;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned D  = 4;

  logic clock = 1'b0;
  logic rst;

  logic [N-1:0]    c_mask, c_rdy, c_mvld, c_mlast;
  logic [DW-1:0]   c_data;
  logic            c_last, c_vld, c_srdy, c_drop;
  logic [N*DW-1:0] c_mdata;

  logic [N-1:0]    f_mask, f_rdy, f_mvld, f_mlast;
  logic [DW-1:0]   f_data;
  logic            f_last, f_vld, f_srdy, f_drop;
  logic [N*DW-1:0] f_mdata;

  always #5 clock = ~clock;

  axis_mirrors_pkt #(.DSIZE(DW), .NUM(N), .DEPTH(D), .MODE("CDS_MODE")) u_cds (
    .clock(clock), .rst(rst), .dest_mask(c_mask),
    .s_tdata(c_data), .s_tlast(c_last), .s_tvalid(c_vld), .s_tready(c_srdy),
    .m_tdata(c_mdata), .m_tlast(c_mlast), .m_tvalid(c_mvld), .m_tready(c_rdy),
    .pkt_drop(c_drop)
  );

  axis_mirrors_pkt #(.DSIZE(DW), .NUM(N), .DEPTH(D), .MODE("FULL_MODE")) u_full (
    .clock(clock), .rst(rst), .dest_mask(f_mask),
    .s_tdata(f_data), .s_tlast(f_last), .s_tvalid(f_vld), .s_tready(f_srdy),
    .m_tdata(f_mdata), .m_tlast(f_mlast), .m_tvalid(f_mvld), .m_tready(f_rdy),
    .pkt_drop(f_drop)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: each enabled channel must pop gdat[0..7] in order, tlast on 7
  logic [DW-1:0] gdat [8];
  int unsigned   sb_idx [N];
  logic          sb_en = 1'b0;

  task automatic score();
    for (int c = 0; c < N; c++) begin
      if (sb_en && c_mvld[c] && c_rdy[c]) begin
        if (sb_idx[c] < 8)
          check($sformatf("sb_ch%0d_beat%0d", c, sb_idx[c]),
                64'({c_mlast[c], c_mdata[c*DW +: DW]}),
                64'({sb_idx[c] == 7, gdat[sb_idx[c]]}));
        else
          check($sformatf("sb_ch%0d_extra_pop", c), 64'(sb_idx[c]), 64'd7);
        sb_idx[c]++;
      end
    end
  endtask

  task automatic apply(input logic vld, input logic [DW-1:0] d, input logic last,
                       input logic [N-1:0] mask, input logic [N-1:0] rdy);
    c_vld = vld; c_data = d; c_last = last; c_mask = mask; c_rdy = rdy;
    #1;
  endtask

  task automatic adv();
    score();
    tick();
  endtask

  typedef struct {
    logic          rst;
    logic          vld;
    logic [DW-1:0] data;
    logic          last;
    logic [N-1:0]  mask;
    logic [N-1:0]  rdy;
    logic          e_srdy;
    logic [N-1:0]  e_mvld;
    logic [DW-1:0] e_data;
    logic          e_last;
    logic          e_drop;
  } vec_t;

  vec_t vt [20];

  initial begin
    int unsigned i;
    logic acc;
    logic done;
    logic [N-1:0] exp_v;
    logic [DW-1:0] fa [3];

    // rst vld data last mask rdy | srdy mvld data last drop
    vt[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b0101, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 32'hB1, 1'b0, 4'b0101, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'hB2, 1'b0, 4'b1010, 4'hF, 1'b1, 4'b0101, 32'hB1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'hB3, 1'b1, 4'b1010, 4'hF, 1'b1, 4'b0101, 32'hB2, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b1010, 4'hF, 1'b1, 4'b0101, 32'hB3, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b0000, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'hC1, 1'b0, 4'b0000, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'hC2, 1'b1, 4'b1111, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b1111, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b1111, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 32'hD1, 1'b1, 4'b0010, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 32'hD2, 1'b1, 4'b0100, 4'hF, 1'b1, 4'b0010, 32'hD1, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b0000, 4'hF, 1'b1, 4'b0100, 32'hD2, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b0000, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b1, 32'hE1, 1'b0, 4'b0011, 4'h0, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b1, 32'hE2, 1'b0, 4'b0011, 4'h0, 1'b1, 4'b0011, 32'hE1, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b1, 32'hE3, 1'b0, 4'b0011, 4'h0, 1'b0, 4'b0011, 32'hE1, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b1, 32'hF1, 1'b1, 4'b1000, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b0000, 4'hF, 1'b1, 4'b1000, 32'hF1, 1'b1, 1'b0};
    vt[19] = '{1'b0, 1'b0, 32'h0,  1'b0, 4'b0000, 4'hF, 1'b1, 4'b0000, 32'h0,  1'b0, 1'b0};

    for (int k = 0; k < 8; k++) gdat[k] = 32'h5000 + 32'(k);
    fa[0] = 32'hA1; fa[1] = 32'hA2; fa[2] = 32'hA3;

    // Reset
    rst = 1'b1;
    c_vld = 0; c_data = '0; c_last = 0; c_mask = '0; c_rdy = '1;
    f_vld = 0; f_data = '0; f_last = 0; f_mask = '0; f_rdy = '1;
    #1;
    check("rst_cds_srdy", 64'(c_srdy), 64'd0);
    check("rst_full_srdy", 64'(f_srdy), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_mvld", 64'(c_mvld), 64'd0);
    check("post_rst_drop", 64'(c_drop), 64'd0);
    check("post_rst_srdy", 64'(c_srdy), 64'd1);
    check("post_rst_full_mvld", 64'(f_mvld), 64'd0);
    tick();

    // FULL_MODE: 3-beat packet, dest_mask held at zero to show it is ignored
    for (int k = 0; k < 5; k++) begin
      f_vld = (k < 3); f_data = fa[(k < 3) ? k : 2]; f_last = (k == 2);
      f_mask = '0; f_rdy = '1;
      #1;
      if (k < 3) check($sformatf("full_srdy_k%0d", k), 64'(f_srdy), 64'd1);
      exp_v = (k >= 1 && k <= 3) ? 4'hF : 4'h0;
      check($sformatf("full_mvld_k%0d", k), 64'(f_mvld), 64'(exp_v));
      if (k >= 1 && k <= 3) begin
        for (int c = 0; c < N; c++)
          check($sformatf("full_k%0d_ch%0d", k, c),
                64'({f_mlast[c], f_mdata[c*DW +: DW]}), 64'({k == 3, fa[k-1]}));
      end
      tick();
    end
    f_vld = 0;

    // Table-driven CDS vectors
    for (int k = 0; k < 20; k++) begin
      rst = vt[k].rst;
      apply(vt[k].vld, vt[k].data, vt[k].last, vt[k].mask, vt[k].rdy);
      check($sformatf("vec%0d_srdy", k), 64'(c_srdy), 64'(vt[k].e_srdy));
      check($sformatf("vec%0d_mvld", k), 64'(c_mvld), 64'(vt[k].e_mvld));
      check($sformatf("vec%0d_drop", k), 64'(c_drop), 64'(vt[k].e_drop));
      for (int c = 0; c < N; c++) begin
        if (vt[k].e_mvld[c])
          check($sformatf("vec%0d_ch%0d_head", k, c),
                64'({c_mlast[c], c_mdata[c*DW +: DW]}), 64'({vt[k].e_last, vt[k].e_data}));
      end
      tick();
    end
    rst = 1'b0;

    // Stall: channel 1 not ready, all-ones mask, 8-beat packet
    sb_en = 1'b1;
    for (int c = 0; c < N; c++) sb_idx[c] = 0;
    i = 0;
    for (int k = 0; k < 9; k++) begin
      apply(1'b1, gdat[i], (i == 7), 4'hF, 4'b1101);
      check($sformatf("stall_srdy_k%0d", k), 64'(c_srdy), 64'(k < 4));
      if (k == 8) begin
        check("stall_mvld", 64'(c_mvld), 64'b0010);
        check("stall_ch1_head", 64'(c_mdata[DW +: DW]), 64'(gdat[0]));
      end
      acc = c_srdy;
      adv();
      if (acc) i++;
    end
    check("stall_accepts", 64'(i), 64'd4);

    // Release channel 1; full channel still blocks input on the release cycle
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      apply((i < 8), gdat[(i < 8) ? i : 7], (i == 7), 4'hF, 4'hF);
      if (k == 0) check("release_srdy_nocomb", 64'(c_srdy), 64'd0);
      if (i == 8 && c_mvld == '0) done = 1'b1;
      acc = c_vld && c_srdy;
      adv();
      if (acc) i++;
    end
    check("release_done", 64'(done), 64'd1);
    for (int c = 0; c < N; c++)
      check($sformatf("release_count_ch%0d", c), 64'(sb_idx[c]), 64'd8);

    // Same stall, channel 1 excluded by mask: back-to-back accepts
    for (int c = 0; c < N; c++) sb_idx[c] = 0;
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, gdat[k], (k == 7), 4'b1101, 4'b1101);
      check($sformatf("excl_srdy_k%0d", k), 64'(c_srdy), 64'd1);
      check($sformatf("excl_ch1_vld_k%0d", k), 64'(c_mvld[1]), 64'd0);
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, '0, 1'b0, 4'b0000, 4'b1101);
      adv();
    end
    for (int c = 0; c < N; c++)
      check($sformatf("excl_count_ch%0d", c), 64'(sb_idx[c]), (c == 1) ? 64'd0 : 64'd8);
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
